// File: rtl/fetch_queue.sv
// fetch_queue: PC -> sync imem read -> {instr, pc} FIFO toward decode.
// Optional perf counters (starve_cnt, flush_cnt) under `FETCH_PERF_CNT_EN.
module fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic                  flush,
    output logic                  pc_stall,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_rd_en,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           starve_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] P_ONE = 1;
    localparam logic [CW-1:0] C_ONE = 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_pc    [DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [CW:0]           w_occ;

    // Reset masks the head so nothing stale is shown while rst is high.
    assign instr_valid = ~rst & (r_count != '0);
    assign w_pop       = instr_valid & instr_ready & ~flush;
    assign w_push      = r_inflight & ~flush;

    // Occupancy after this cycle counts the read still in flight.
    assign w_occ   = {1'b0, r_count}
                   + (CW+1)'(r_inflight)
                   - (CW+1)'(w_pop);
    assign w_issue = ~rst & ~flush & (w_occ < {1'b0, C_FULL});

    assign imem_addr  = PC;
    assign imem_rd_en = w_issue;
    assign pc_stall   = ~rst & ~flush & ~w_issue;

    assign instr    = instr_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign instr_pc = instr_valid ? r_mem_pc[r_rd_ptr]    : '0;

    // Storage write: returning data tagged with the PC that requested it.
    always_ff @(posedge clk) begin
        if (~rst & w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
        end
    end

    // Control state: reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else if (flush) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue)
                r_inflight_pc <= PC;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + P_ONE;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + P_ONE;
            if (w_push & ~w_pop)
                r_count <= r_count + C_ONE;
            else if (~w_push & w_pop)
                r_count <= r_count - C_ONE;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && r_count == C_FULL));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_starve_cnt;
    logic [31:0] r_flush_cnt;

    // Decode-starved cycles and flush events, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (flush)
                r_flush_cnt <= r_flush_cnt + 32'd1;
            if (instr_ready & ~instr_valid & ~flush)
                r_starve_cnt <= r_starve_cnt + 32'd1;
        end
    end

    assign starve_cnt = r_starve_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scenario tasks plus randomized run against a queue model.
// Perf counter checks compile in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        instr_ready;
    logic [31:0] PC;
    logic [31:0] imem_rdata;
    logic        pc_stall;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] starve_cnt;
    logic [31:0] flush_cnt;
`endif

    fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .PC(PC),
        .flush(flush),
        .pc_stall(pc_stall),
        .imem_addr(imem_addr),
        .imem_rd_en(imem_rd_en),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .starve_cnt(starve_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] p;
    } ent_t;

    // Model: FIFO contents, outstanding memory read, PC stage, counters.
    ent_t        mq[$];
    bit          m_inf;
    logic [31:0] m_inf_pc;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic [31:0] m_starve;
    logic [31:0] m_flushc;

    bit          e_valid, e_pop, e_issue, e_stall;
    logic [98:0] e_vec;
    int          ntot, npass;

    function automatic logic [98:0] got();
        return {instr_valid, instr, instr_pc, imem_rd_en, pc_stall, imem_addr};
    endfunction

    // Drive one cycle's inputs at negedge and derive expected outputs.
    task automatic drive(input bit r, input bit f, input bit rdy,
                         input logic [31:0] tgt);
        logic [31:0] ei, ep;
        rst         = r;
        flush       = f;
        instr_ready = rdy;
        PC          = m_pc;
        m_tgt       = tgt;
        imem_rdata  = m_inf ? (m_inf_pc + 32'h1000) : $urandom;
        e_valid = !r && (mq.size() != 0);
        ei = 32'h0;
        ep = 32'h0;
        if (e_valid) begin
            ei = mq[0].i;
            ep = mq[0].p;
        end
        e_pop   = e_valid && rdy && !f;
        e_issue = !r && !f &&
                  ((mq.size() + int'(m_inf) - int'(e_pop)) < DEPTH);
        e_stall = !r && !f && !e_issue;
        e_vec   = {e_valid, ei, ep, e_issue, e_stall, m_pc};
        #1;
    endtask

    // Apply the clock edge to the model, then move to the next negedge.
    task automatic advance();
        if (rst) begin
            mq.delete();
            m_inf    = 1'b0;
            m_starve = 32'h0;
            m_flushc = 32'h0;
            m_pc     = 32'h0;
        end else begin
            if (instr_ready && !e_valid && !flush)
                m_starve++;
            if (flush) begin
                mq.delete();
                m_inf = 1'b0;
                m_flushc++;
                m_pc = m_tgt;
            end else begin
                if (e_pop)
                    void'(mq.pop_front());
                if (m_inf)
                    mq.push_back('{m_inf_pc + 32'h1000, m_inf_pc});
                m_inf    = e_issue;
                m_inf_pc = m_pc;
                if (!e_stall)
                    m_pc += 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, k[0], 32'h0);
            ntot++;
            if ({instr_valid, instr, instr_pc, imem_rd_en, pc_stall} !== 67'h0)
                $display("FAIL reset_out cyc %0d: got %h want 0", k,
                         {instr_valid, instr, instr_pc, imem_rd_en, pc_stall});
            else
                npass++;
`ifdef FETCH_PERF_CNT_EN
            ntot++;
            if ({starve_cnt, flush_cnt} !== 64'h0)
                $display("FAIL reset_cnt cyc %0d: got %h want 0", k,
                         {starve_cnt, flush_cnt});
            else
                npass++;
`endif
            advance();
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 14; k++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0);
            ntot++;
            if (got() !== e_vec)
                $display("FAIL stream cyc %0d: got %h want %h", k, got(), e_vec);
            else
                npass++;
            ntot++;
            if (k < 2) begin
                if (instr_valid !== 1'b0)
                    $display("FAIL stream_lat cyc %0d: valid %b want 0",
                             k, instr_valid);
                else
                    npass++;
            end else begin
                if ({instr_valid, instr_pc, instr, pc_stall} !==
                    {1'b1, 32'(4*(k-2)), 32'(4*(k-2)) + 32'h1000, 1'b0})
                    $display("FAIL stream_seq cyc %0d: v %b pc %h i %h st %b want pc %h",
                             k, instr_valid, instr_pc, instr, pc_stall, 4*(k-2));
                else
                    npass++;
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int nissue = 0;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        advance();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            if (imem_rd_en === 1'b1)
                nissue++;
            ntot++;
            if (got() !== e_vec)
                $display("FAIL bp_hold cyc %0d: got %h want %h", k, got(), e_vec);
            else
                npass++;
            ntot++;
            if (pc_stall !== (k >= 4))
                $display("FAIL bp_stall cyc %0d: got %b want %b",
                         k, pc_stall, k >= 4);
            else
                npass++;
            advance();
        end
        ntot++;
        if (nissue != 4)
            $display("FAIL bp_issues: got %0d want 4", nissue);
        else
            npass++;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0);
            ntot++;
            if (got() !== e_vec)
                $display("FAIL bp_drain cyc %0d: got %h want %h", k, got(), e_vec);
            else
                npass++;
            if (k < 4) begin
                ntot++;
                if ({instr_valid, instr_pc} !== {1'b1, 32'(4*k)})
                    $display("FAIL bp_order cyc %0d: v %b pc %h want pc %h",
                             k, instr_valid, instr_pc, 4*k);
                else
                    npass++;
            end
            if (k == 0) begin
                ntot++;
                if ({imem_rd_en, imem_addr} !== {1'b1, 32'h10})
                    $display("FAIL bp_resume: en %b addr %h want 1 00000010",
                             imem_rd_en, imem_addr);
                else
                    npass++;
            end
            advance();
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            advance();
        end
        drive(1'b0, 1'b1, 1'b0, 32'h100);
        ntot++;
        if ({got(), imem_rd_en, pc_stall} !== {e_vec, 2'b00})
            $display("FAIL flush_cyc: got %h want %h", got(), e_vec);
        else
            npass++;
        advance();
        for (int j = 0; j < 6; j++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0);
            ntot++;
            if (got() !== e_vec)
                $display("FAIL flush_after cyc %0d: got %h want %h", j, got(), e_vec);
            else
                npass++;
            ntot++;
            if (j < 2 && instr_valid !== 1'b0)
                $display("FAIL flush_empty cyc %0d: valid %b want 0", j, instr_valid);
            else if (j == 2 && {instr_valid, instr_pc, instr} !==
                               {1'b1, 32'h100, 32'h1100})
                $display("FAIL flush_target: v %b pc %h i %h want 1 100 1100",
                         instr_valid, instr_pc, instr);
            else if (instr_valid === 1'b1 && instr_pc < 32'h100)
                $display("FAIL flush_stale cyc %0d: pc %h", j, instr_pc);
            else
                npass++;
            advance();
        end
    endtask

    task automatic test_flush_pop();
        logic [31:0] fc0;
        for (int k = 0; k < 5 && !instr_valid; k++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0);
            advance();
        end
        drive(1'b0, 1'b1, 1'b1, 32'h40);
`ifdef FETCH_PERF_CNT_EN
        fc0 = m_flushc;
`else
        fc0 = 32'h0;
`endif
        ntot++;
        if ({instr_valid, got()} !== {1'b1, e_vec})
            $display("FAIL fpop_cyc: v %b got %h want %h", instr_valid, got(), e_vec);
        else
            npass++;
        advance();
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0);
            ntot++;
            if (got() !== e_vec)
                $display("FAIL fpop_after cyc %0d: got %h want %h", j, got(), e_vec);
            else
                npass++;
            if (j == 0) begin
                ntot++;
                if (instr_valid !== 1'b0)
                    $display("FAIL fpop_empty: valid %b want 0", instr_valid);
                else
                    npass++;
`ifdef FETCH_PERF_CNT_EN
                ntot++;
                if (flush_cnt !== fc0 + 32'd1)
                    $display("FAIL fpop_fcnt: got %0d want %0d", flush_cnt, fc0 + 1);
                else
                    npass++;
`endif
            end
            if (j == 2) begin
                ntot++;
                if ({instr_valid, instr_pc} !== {1'b1, 32'h40})
                    $display("FAIL fpop_target: v %b pc %h want 1 40",
                             instr_valid, instr_pc);
                else
                    npass++;
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 32'h200);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            advance();
        end
        drive(1'b1, 1'b0, 1'b1, 32'h0);
        ntot++;
        if (got() !== e_vec)
            $display("FAIL rmid_cyc: got %h want %h", got(), e_vec);
        else
            npass++;
        advance();
        for (int j = 0; j < 6; j++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0);
            ntot++;
            if (got() !== e_vec)
                $display("FAIL rmid_after cyc %0d: got %h want %h", j, got(), e_vec);
            else
                npass++;
            ntot++;
            if (j == 0 && {instr_valid, instr, instr_pc} !== 65'h0)
                $display("FAIL rmid_clear: v %b i %h pc %h want 0",
                         instr_valid, instr, instr_pc);
            else if (j == 2 && {instr_valid, instr_pc} !== {1'b1, 32'h0})
                $display("FAIL rmid_resume: v %b pc %h want 1 0",
                         instr_valid, instr_pc);
            else if (instr_valid === 1'b1 && instr_pc >= 32'h200)
                $display("FAIL rmid_stale cyc %0d: pc %h", j, instr_pc);
            else
                npass++;
            advance();
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        for (int k = 0; k < 14; k++) begin
            drive(1'b0, (k >= 3 && k < 8), 1'b1, 32'($urandom_range(0, 63)) << 2);
            ntot++;
            if ({got(), starve_cnt, flush_cnt} !== {e_vec, m_starve, m_flushc})
                $display("FAIL perf cyc %0d: st %0d fl %0d want %0d %0d",
                         k, starve_cnt, flush_cnt, m_starve, m_flushc);
            else
                npass++;
            advance();
        end
    endtask
`endif

    task automatic test_random();
        bit r, f, rdy;
        for (int k = 0; k < 400; k++) begin
            r   = ($urandom_range(0, 49) == 0);
            f   = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            drive(r, f, rdy, 32'($urandom_range(0, 1023)) << 2);
            ntot++;
            if (got() !== e_vec)
                $display("FAIL random cyc %0d: got %h want %h", k, got(), e_vec);
            else
                npass++;
`ifdef FETCH_PERF_CNT_EN
            ntot++;
            if ({starve_cnt, flush_cnt} !== {m_starve, m_flushc})
                $display("FAIL random_cnt cyc %0d: got %0d %0d want %0d %0d",
                         k, starve_cnt, flush_cnt, m_starve, m_flushc);
            else
                npass++;
`endif
            advance();
        end
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        instr_ready = 1'b0;
        PC          = 32'h0;
        imem_rdata  = 32'h0;
        mq.delete();
        m_inf    = 1'b0;
        m_inf_pc = 32'h0;
        m_pc     = 32'h0;
        m_tgt    = 32'h0;
        m_starve = 32'h0;
        m_flushc = 32'h0;
        ntot     = 0;
        npass    = 0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_pop();
        test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
